// File: rtl/uart_tx_fifo.sv
// Fabric-side UART transmitter: byte FIFO feeding an 8N1 serialiser.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 frames).
`timescale 1ns/1ps
module uart_tx_fifo #(
    parameter int BAUD_DIV   = 434,
    parameter int FIFO_DEPTH = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [7:0]                      tx_data,
    input  logic                            tx_valid,
    output logic                            tx_ready,
    output logic                            tx,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            overflow
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(BAUD_DIV);

    localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    state_t state;
    state_t state_n;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_n;

    logic [BW-1:0] baud;
    logic [BW-1:0] baud_n;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_n;
    logic [7:0]    shift;
    logic [7:0]    shift_n;

    logic push;
    logic pop;
    logic bit_end;
    logic frame_end;
    logic tx_n;
    logic busy_n;

`ifdef UART_TX_PARITY_EN
    logic parity;
    logic parity_n;
`endif

    assign tx_ready  = (fifo_count != FULL);
    assign push      = tx_valid && tx_ready;
    assign bit_end   = (baud == BAUD_LAST);
    assign frame_end = (state == STOP) && bit_end && (bit_idx == STOP_LAST);
    // Popping on the last stop cycle chains frames with no idle gap.
    assign pop       = ((state == IDLE) || frame_end) && (fifo_count != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        baud_n    = baud + BW'(1);
        bit_idx_n = bit_idx;
        shift_n   = shift;
`ifdef UART_TX_PARITY_EN
        parity_n  = parity;
`endif
        unique case (state)
            IDLE: begin
                baud_n = '0;
            end
            START: begin
                if (bit_end) begin
                    state_n   = DATA;
                    baud_n    = '0;
                    bit_idx_n = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_n = '0;
                    if (bit_idx == 3'd7) begin
                        bit_idx_n = '0;
`ifdef UART_TX_PARITY_EN
                        state_n   = PARITY;
`else
                        state_n   = STOP;
`endif
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        shift_n   = {1'b0, shift[7:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_n   = STOP;
                    baud_n    = '0;
                    bit_idx_n = '0;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    baud_n = '0;
                    if (bit_idx == STOP_LAST) begin
                        state_n = IDLE;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                baud_n  = '0;
            end
        endcase
        if (pop) begin
            state_n   = START;
            baud_n    = '0;
            bit_idx_n = '0;
            shift_n   = mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
            parity_n  = ^mem[rd_ptr];
`endif
        end
    end

    always_comb begin
        count_n = fifo_count;
        if (push && !pop) begin
            count_n = fifo_count + CW'(1);
        end else if (pop && !push) begin
            count_n = fifo_count - CW'(1);
        end
    end

    // tx and busy are registered from next-state values so they line up
    // with the state they describe.
    always_comb begin
        tx_n = 1'b1;
        unique case (state_n)
            IDLE:   tx_n = 1'b1;
            START:  tx_n = 1'b0;
            DATA:   tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_n = parity_n;
`endif
            STOP:   tx_n = 1'b1;
            default: tx_n = 1'b1;
        endcase
        busy_n = (state_n != IDLE) || (count_n != '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx         <= 1'b1;
            busy       <= 1'b0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            baud       <= '0;
            bit_idx    <= '0;
            shift      <= '0;
`ifdef UART_TX_PARITY_EN
            parity     <= 1'b0;
`endif
        end else begin
            tx         <= tx_n;
            busy       <= busy_n;
            fifo_count <= count_n;
            baud       <= baud_n;
            bit_idx    <= bit_idx_n;
            shift      <= shift_n;
`ifdef UART_TX_PARITY_EN
            parity     <= parity_n;
`endif
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (tx_valid && !tx_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: a serial monitor decodes tx
// and compares each received frame with the queued expected byte.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int BD    = 4;
    localparam int DEPTH = 4;
    localparam int SB    = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PAR   = 1;
`else
    localparam int PAR   = 0;
`endif
    localparam int NB    = 10 + SB - 1 + PAR;
    localparam int FRAME = NB * BD;

    logic       clock;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    bit         par_q[$];
    time        start_t[$];

    uart_tx_fifo #(
        .BAUD_DIV  (BD),
        .FIFO_DEPTH(DEPTH),
        .STOP_BITS (SB)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx        (tx),
        .busy      (busy),
        .fifo_count(fifo_count),
        .overflow  (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Serial monitor: samples tx on falling edges, one bit per BD samples.
    int         mon_bit = -1;
    int         mon_sub = 0;
    logic       cur;
    logic       glitch;
    logic [15:0] fr;

    task automatic eval_frame();
        logic [7:0] d;
        d = fr[8:1];
        check("start_bit", {31'd0, fr[0]}, 32'd0);
        check("bit_stable", {31'd0, glitch}, 32'd0);
        for (int s = 0; s < SB; s++) begin
            check("stop_bit", {31'd0, fr[NB-1-s]}, 32'd1);
        end
`ifdef UART_TX_PARITY_EN
        check("parity_bit", {31'd0, fr[9]}, {31'd0, ^d});
        par_q.push_back(fr[9]);
`endif
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got %02h expected none", d);
        end else begin
            check("rx_byte", {24'd0, d}, {24'd0, exp_q.pop_front()});
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            mon_bit = -1;
        end else if (mon_bit >= 0) begin
            if (mon_sub == 0) begin
                cur = tx;
            end else if (tx !== cur) begin
                glitch = 1'b1;
            end
            mon_sub++;
            if (mon_sub == BD) begin
                fr[mon_bit] = cur;
                mon_sub = 0;
                mon_bit++;
                if (mon_bit == NB) begin
                    eval_frame();
                    mon_bit = -1;
                end
            end
        end else if (tx === 1'b0) begin
            start_t.push_back($time);
            fr      = '0;
            cur     = 1'b0;
            glitch  = 1'b0;
            mon_bit = 0;
            mon_sub = 1;
        end
    end

    task automatic push(input logic [7:0] b, input bit acc);
        check("tx_ready_pre", {31'd0, tx_ready}, {31'd0, acc});
        if (acc) exp_q.push_back(b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clock);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        reset    = 1'b1;
        tx_data  = 8'h00;
        tx_valid = 1'b0;

        // Reset values
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_count", {29'd0, fifo_count}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);

        // Single byte: latency, frame length, busy fall
        push(8'hA5, 1'b1);
        check("a5_count_n", {29'd0, fifo_count}, 32'd1);
        check("a5_busy_n", {31'd0, busy}, 32'd1);
        check("a5_tx_n", {31'd0, tx}, 32'd1);
        @(posedge clock);
        #1;
        check("a5_tx_n1", {31'd0, tx}, 32'd0);
        check("a5_count_n1", {29'd0, fifo_count}, 32'd0);
        repeat (FRAME - 1) @(posedge clock);
        #1;
        check("a5_busy_last", {31'd0, busy}, 32'd1);
        check("a5_stop_last", {31'd0, tx}, 32'd1);
        @(posedge clock);
        #1;
        check("a5_busy_fall", {31'd0, busy}, 32'd0);
        wait_idle(4 * FRAME);

        // Back-to-back bytes: no idle gap between frames
        start_t.delete();
        push(8'h00, 1'b1);
        check("b2b_count0", {29'd0, fifo_count}, 32'd1);
        push(8'hFF, 1'b1);
        check("b2b_count1", {29'd0, fifo_count}, 32'd1);
        repeat (FRAME - 1) @(posedge clock);
        #1;
        check("b2b_count_pre", {29'd0, fifo_count}, 32'd1);
        @(posedge clock);
        #1;
        check("b2b_count2", {29'd0, fifo_count}, 32'd0);
        check("b2b_tx_start2", {31'd0, tx}, 32'd0);
        wait_idle(4 * FRAME);
        check("b2b_frames", start_t.size(), 32'd2);
        if (start_t.size() == 2) begin
            check("b2b_gap", 32'(start_t[1] - start_t[0]), 32'(FRAME * 10));
        end

        // Full FIFO and overflow, then a second fill over wrapped pointers
        push(8'h5A, 1'b1);
        @(posedge clock);
        #1;
        push(8'h01, 1'b1);
        push(8'h02, 1'b1);
        push(8'h03, 1'b1);
        push(8'h04, 1'b1);
        check("full_count", {29'd0, fifo_count}, 32'd4);
        check("full_ready", {31'd0, tx_ready}, 32'd0);
        check("ovf_before", {31'd0, overflow}, 32'd0);
        push(8'h05, 1'b0);
        check("ovf_set", {31'd0, overflow}, 32'd1);
        check("ovf_count", {29'd0, fifo_count}, 32'd4);
        wait_idle(8 * FRAME);

        push(8'h66, 1'b1);
        @(posedge clock);
        #1;
        push(8'h11, 1'b1);
        push(8'h12, 1'b1);
        push(8'h13, 1'b1);
        push(8'h14, 1'b1);
        check("full2_ready", {31'd0, tx_ready}, 32'd0);
        push(8'h15, 1'b0);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        wait_idle(8 * FRAME);
        check("sb_drained_fill", exp_q.size(), 32'd0);

        // Reset during data bit 3 with another byte queued
        push(8'h3C, 1'b1);
        push(8'hC3, 1'b1);
        repeat (17) @(posedge clock);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(posedge clock);
        #1;
        check("mid_rst_tx", {31'd0, tx}, 32'd1);
        check("mid_rst_count", {29'd0, fifo_count}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
        reset = 1'b0;
        lows = 0;
        repeat (3 * FRAME) begin
            @(posedge clock);
            #1;
            if (tx !== 1'b1) lows++;
        end
        check("post_rst_quiet", lows, 32'd0);

`ifdef UART_TX_PARITY_EN
        par_q.delete();
        push(8'h07, 1'b1);
        push(8'h03, 1'b1);
        wait_idle(4 * FRAME);
        check("par_frames", par_q.size(), 32'd2);
        if (par_q.size() == 2) begin
            check("par_07", {31'd0, par_q[0]}, 32'd1);
            check("par_03", {31'd0, par_q[1]}, 32'd0);
        end
`endif

        check("sb_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
